// File: rtl/puneh_mem_io_unit.sv
// PUNEH memory-side bus slave: word RAM, STATUS register and an output
// port FIFO drained by an external consumer over valid/ready.
module puneh_mem_io_unit #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8,
    parameter     INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addrBus,
    input  logic        readMEM,
    input  logic        writeMEM,
    inout  wire  [15:0] dataBus,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   ram  [2**ADDR_WIDTH];
    logic [15:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic          ram_sel;
    logic          stat_sel;
    logic          port_sel;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic [15:0]   status;
    logic [15:0]   rdata;

    assign ram_sel  = (({16'b0, addrBus} >> ADDR_WIDTH) == 32'd0);
    assign stat_sel = (addrBus == 16'hFFFE);
    assign port_sel = (addrBus == 16'hFFFF);

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = out_valid && out_ready;
    // A pop frees a slot on the same edge, so a push into a full FIFO
    // still lands when the consumer is taking the head.
    assign push  = writeMEM && port_sel && (!full || pop);
    assign drop  = writeMEM && port_sel && full && !pop;

    assign status = {7'b0, 6'(count), ovf, full, empty};

    always_comb begin
        rdata = 16'h0000;
        unique case (1'b1)
            ram_sel:  rdata = ram[addrBus[ADDR_WIDTH-1:0]];
            stat_sel: rdata = status;
            default:  rdata = 16'h0000;
        endcase
    end

    assign dataBus = (readMEM && !writeMEM) ? rdata : 16'hzzzz;

    always_ff @(posedge clk) begin
        if (writeMEM && ram_sel) ram[addrBus[ADDR_WIDTH-1:0]] <= dataBus;
    end

    always_ff @(posedge clk) begin
        if (rst && push) fifo[wptr] <= dataBus;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop)                     ovf <= 1'b1;
            else if (readMEM && stat_sel) ovf <= 1'b0;
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? 16'h0000 : fifo[rptr];
    assign overflow  = ovf;

    a_no_rw_clash: assert property (
        @(posedge clk) disable iff (!rst) !(readMEM && writeMEM)
    );

endmodule

// File: tb/tb_puneh_mem_io_unit.sv
// Directed bench for puneh_mem_io_unit: vector table for bus access,
// hand sequences for FIFO fill, overflow, drain, push+pop and reset.
module tb_puneh_mem_io_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addrBus = '0;
    logic        readMEM = 1'b0;
    logic        writeMEM = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        overflow;
    logic        tb_en = 1'b0;
    logic [15:0] tb_drv = '0;
    wire  [15:0] dataBus;

    int n_cmp = 0;
    int n_bad = 0;

    assign dataBus = tb_en ? tb_drv : 16'hzzzz;

    always #5 clk = ~clk;

    puneh_mem_io_unit #(.ADDR_WIDTH(12), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addrBus(addrBus),
        .readMEM(readMEM), .writeMEM(writeMEM), .dataBus(dataBus),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
    );

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addrBus = a; tb_drv = d; tb_en = 1'b1; writeMEM = 1'b1;
        @(posedge clk); #1;
        writeMEM = 1'b0; tb_en = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [15:0] a,
                            input logic [15:0] exp);
        @(negedge clk);
        addrBus = a; readMEM = 1'b1;
        #1 check(name, dataBus, exp);
        @(posedge clk); #1;
        readMEM = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h0005, 16'hBEEF, 16'h0000, "wr_0005"};
        vecs[1] = '{1, 16'h0005, 16'h0000, 16'hBEEF, "rd_0005"};
        vecs[2] = '{2, 16'h0005, 16'h5555, 16'h5555, "float_0005"};
        vecs[3] = '{0, 16'h0000, 16'h5A5A, 16'h0000, "wr_0000"};
        vecs[4] = '{0, 16'h2000, 16'h1234, 16'h0000, "wr_2000"};
        vecs[5] = '{1, 16'h2000, 16'h0000, 16'h0000, "rd_2000"};
        vecs[6] = '{1, 16'h0000, 16'h0000, 16'h5A5A, "rd_0000"};
        vecs[7] = '{1, 16'hFFFF, 16'h0000, 16'h0000, "rd_outport"};
        vecs[8] = '{1, 16'h0FFF, 16'h0000, 16'h0000, "rd_0fff"};
        vecs[9] = '{1, 16'hFFFE, 16'h0000, 16'h0001, "rd_status0"};

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("rst_valid", {15'b0, out_valid}, 16'h0000);
        check("rst_data", out_data, 16'h0000);
        check("rst_ovf", {15'b0, overflow}, 16'h0000);

        bus_write(16'h0FFF, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            addrBus  = vecs[i].addr;
            tb_drv   = vecs[i].data;
            tb_en    = (vecs[i].kind != 1);
            writeMEM = (vecs[i].kind == 0);
            readMEM  = (vecs[i].kind == 1);
            #1;
            if (vecs[i].kind != 0) check(vecs[i].name, dataBus, vecs[i].exp);
            @(posedge clk); #1;
            writeMEM = 1'b0; readMEM = 1'b0; tb_en = 1'b0;
        end

        for (int i = 1; i <= 8; i++) bus_write(16'hFFFF, 16'(i));
        check("fill_head", out_data, 16'h0001);
        bus_read("st_full", 16'hFFFE, 16'h0042);
        bus_write(16'hFFFF, 16'h0009);
        check("ovf_flag", {15'b0, overflow}, 16'h0001);
        bus_read("st_ovf", 16'hFFFE, 16'h0046);
        bus_read("st_ovf_clr", 16'hFFFE, 16'h0042);
        check("head_stable", out_data, 16'h0001);

        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1 check("drain_valid", {15'b0, out_valid}, 16'h0001);
            check("drain_data", out_data, 16'(i));
            @(posedge clk); #1;
        end
        check("drain_empty", {15'b0, out_valid}, 16'h0000);
        out_ready = 1'b0;
        bus_read("st_empty", 16'hFFFE, 16'h0001);

        for (int i = 1; i <= 8; i++) bus_write(16'hFFFF, 16'h0010 + 16'(i));
        @(negedge clk);
        out_ready = 1'b1;
        addrBus = 16'hFFFF; tb_drv = 16'hAAAA; tb_en = 1'b1;
        writeMEM = 1'b1;
        @(posedge clk); #1;
        writeMEM = 1'b0; tb_en = 1'b0; out_ready = 1'b0;
        check("pp_ovf", {15'b0, overflow}, 16'h0000);
        bus_read("st_pp", 16'hFFFE, 16'h0042);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            #1 check("pp_drain", out_data,
                     (i == 9) ? 16'hAAAA : 16'h0010 + 16'(i));
            @(posedge clk); #1;
        end
        check("pp_empty", {15'b0, out_valid}, 16'h0000);
        out_ready = 1'b0;

        for (int i = 1; i <= 3; i++) bus_write(16'hFFFF, 16'h0030 + 16'(i));
        check("pre_rst_valid", {15'b0, out_valid}, 16'h0001);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("mid_rst_valid", {15'b0, out_valid}, 16'h0000);
        check("mid_rst_data", out_data, 16'h0000);
        bus_read("mid_rst_st", 16'hFFFE, 16'h0001);
        bus_read("mid_rst_ram", 16'h0005, 16'hBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
